// File: rtl/fnd_pkg.sv
// Shared types, constants and segment decoder for the FND scan controller.
package fnd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    localparam int          BIN_W     = 14;
    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [13:0] MAX_VAL   = 14'd9999;

    // BCD digit to active-low {g,f,e,d,c,b,a}; non-decimal codes go dark.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Sequential double-dabble converter: 14-bit binary to four BCD digits.
module bin2bcd_dd
    import fnd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    conv_state_t state, state_nx;
    logic [15:0] bcd_r;
    logic [13:0] bin_r;
    logic [3:0]  iter;
    logic [29:0] shifted;

    // Add 3 to every nibble that is 5 or more so the next shift carries correctly.
    function automatic logic [15:0] dab_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign shifted = {dab_adjust(bcd_r), bin_r} << 1;
    assign bcd     = bcd_r;

    // State register plus shift register / iteration counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            bcd_r <= '0;
            bin_r <= '0;
            iter  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    bin_r <= bin;
                    bcd_r <= '0;
                    iter  <= '0;
                end
                SHIFT: begin
                    bcd_r <= shifted[29:14];
                    bin_r <= shifted[13:0];
                    iter  <= iter + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Next state and status outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = SHIFT;
            end
            SHIFT: if (iter == 4'(BIN_W - 1)) state_nx = DONE;
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode multiplexed 7-segment driver with binary-to-BCD front end.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] i_data,
    input  logic        i_load,
    input  logic [3:0]  i_dp,
    output logic        o_busy,
    output logic [3:0]  o_fnd_com,
    output logic [7:0]  o_fnd_data
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [13:0]      bin_sat;
    logic             start, conv_busy, conv_done;
    logic [15:0]      conv_bcd, disp;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [1:0]       idx;
    logic [3:0]       blank;
    logic [6:0]       seg_nx;

    // Out-of-range values are clamped so the display never shows a wrapped number.
    assign bin_sat = (i_data > MAX_VAL) ? MAX_VAL : i_data;
    assign start   = i_load & ~conv_busy;
    assign o_busy  = conv_busy;
    assign tick    = (cnt == CNT_W'(DIV - 1));

    bin2bcd_dd u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin_sat),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Display registers take all four digits at once when conversion finishes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) disp <= '0;
        else if (conv_done) disp <= conv_bcd;
    end

    // Prescaler and digit index; the scan keeps running during conversion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Leading-zero blanking cascades down from the top digit; digit 0 always lit.
    always_comb begin
        blank    = '0;
        blank[3] = (BLANK_LZ != 0) && (disp[15:12] == 4'd0);
        blank[2] = blank[3] && (disp[11:8] == 4'd0);
        blank[1] = blank[2] && (disp[7:4] == 4'd0);
        seg_nx   = blank[idx] ? SEG_BLANK : seg7(disp[{idx, 2'b00} +: 4]);
    end

    // Common and segment outputs registered together so they switch in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_fnd_com  <= 4'b1110;
            o_fnd_data <= 8'hC0;
        end else begin
            o_fnd_com  <= ~(4'b0001 << idx);
            o_fnd_data <= {~i_dp[idx], seg_nx};
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with a reduced scan divider of 8.
module tb_fnd_scan_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] i_data;
    logic        i_load;
    logic [3:0]  i_dp;
    logic        busy_lz, busy_nb;
    logic [3:0]  com_lz, com_nb;
    logic [7:0]  data_lz, data_nb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fnd_scan_controller #(.CLK_HZ(8), .SCAN_HZ(1), .BLANK_LZ(1)) dut_lz (
        .clk(clk), .reset(reset), .i_data(i_data), .i_load(i_load), .i_dp(i_dp),
        .o_busy(busy_lz), .o_fnd_com(com_lz), .o_fnd_data(data_lz)
    );

    fnd_scan_controller #(.CLK_HZ(8), .SCAN_HZ(1), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .reset(reset), .i_data(i_data), .i_load(i_load), .i_dp(i_dp),
        .o_busy(busy_nb), .o_fnd_com(com_nb), .o_fnd_data(data_nb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for digit k to be selected, then return its segment byte.
    task automatic get_digit(input int k, input bit nb, output logic [7:0] seg);
        logic [3:0] want;
        bit found;
        want  = ~(4'b0001 << k);
        found = 1'b0;
        seg   = 8'hxx;
        for (int n = 0; n < 80 && !found; n++) begin
            @(negedge clk);
            if ((nb ? com_nb : com_lz) == want) begin
                found = 1'b1;
                seg   = nb ? data_nb : data_lz;
            end
        end
        if (!found) chk("scan_timeout", {28'd0, (nb ? com_nb : com_lz)}, {28'd0, want});
    endtask

    task automatic check_digits(input string tag, input bit nb,
                                input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] s;
        get_digit(0, nb, s); chk({tag, "_d0"}, s, e0);
        get_digit(1, nb, s); chk({tag, "_d1"}, s, e1);
        get_digit(2, nb, s); chk({tag, "_d2"}, s, e2);
        get_digit(3, nb, s); chk({tag, "_d3"}, s, e3);
    endtask

    task automatic wait_idle(output int nbusy);
        nbusy = 0;
        while (busy_lz && nbusy < 40) begin
            nbusy++;
            @(negedge clk);
        end
    endtask

    // One-cycle load strobe; returns at the first negedge where busy is low.
    task automatic do_load(input logic [13:0] v, output int nbusy);
        @(negedge clk);
        i_data = v;
        i_load = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        wait_idle(nbusy);
    endtask

    initial begin
        int n;
        logic [7:0] s;

        reset  = 1'b0;
        i_load = 1'b0;
        i_data = '0;
        i_dp   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_lz, 1'b0);
        chk("rst_com",  com_lz, 4'b1110);
        chk("rst_data", data_lz, 8'hC0);
        reset = 1'b1;

        do_load(14'd1234, n);
        chk("busy_len", n, 15);
        chk("busy_len_nb", busy_nb, 1'b0);
        check_digits("v1234", 1'b0, 8'h99, 8'hB0, 8'hA4, 8'hF9);

        do_load(14'd7, n);
        check_digits("v7_lz", 1'b0, 8'hF8, 8'hFF, 8'hFF, 8'hFF);
        check_digits("v7_nb", 1'b1, 8'hF8, 8'hC0, 8'hC0, 8'hC0);

        do_load(14'd0, n);
        check_digits("v0", 1'b0, 8'hC0, 8'hFF, 8'hFF, 8'hFF);

        do_load(14'h3FFF, n);
        check_digits("sat", 1'b0, 8'h90, 8'h90, 8'h90, 8'h90);
        i_dp = 4'b0100;
        get_digit(2, 1'b0, s); chk("dp_d2", s, 8'h10);
        get_digit(0, 1'b0, s); chk("dp_d0", s, 8'h90);
        i_dp = 4'b0000;

        // Second strobe while busy must be dropped.
        @(negedge clk);
        i_data = 14'd1234;
        i_load = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        repeat (3) @(negedge clk);
        i_data = 14'd5678;
        i_load = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        wait_idle(n);
        chk("drop_busy", n, 11);
        check_digits("drop", 1'b0, 8'h99, 8'hB0, 8'hA4, 8'hF9);

        // Strobe in the cycle busy falls is accepted.
        do_load(14'd1111, n);
        i_data = 14'd5678;
        i_load = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        chk("fall_accept", busy_lz, 1'b1);
        wait_idle(n);
        chk("fall_busy", n, 15);
        check_digits("v5678", 1'b0, 8'h80, 8'hF8, 8'h82, 8'h92);

        // Reset six cycles into a conversion.
        @(negedge clk);
        i_data = 14'd4321;
        i_load = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy_lz, 1'b0);
        chk("mid_rst_com",  com_lz, 4'b1110);
        chk("mid_rst_data", data_lz, 8'hC0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("scan_hold_d0", com_lz, 4'b1110);
        chk("after_rst_busy", busy_lz, 1'b0);
        @(negedge clk);
        chk("scan_step_d1", com_lz, 4'b1101);
        check_digits("after_rst", 1'b0, 8'hC0, 8'hFF, 8'hFF, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
